// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: streaming WIDTH-bit adder/subtractor with one carry-chain
// slice of CHUNK bits per pipeline stage. It accepts one operation per clock.
// Each result appears exactly STAGES = WIDTH/CHUNK cycles after its operands.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   a/b/c_in/sub carry a new operation this cycle
//   a, b       WIDTH-bit operands (unsigned or two's complement)
//   c_in       carry-in (add) or borrow-in (sub)
//   sub        0 = a + b + c_in, 1 = a - b - c_in
//   out_valid  s/c_out/ovf were loaded with a new result this cycle
//   s          sum/difference modulo 2^WIDTH (holds the last result otherwise)
//   c_out      carry out of the MSB; for sub, 1 means no borrow
//   ovf        signed two's-complement overflow
module pipelined_add_sub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  // A partial top chunk would have no stage to compute it.
  if ((WIDTH % CHUNK) != 0) begin : g_width_check
    $error("pipelined_add_sub: WIDTH must be an integer multiple of CHUNK");
  end

  // Subtraction is computed as a + ~b + ~borrow_in.
  logic [WIDTH-1:0] b_eff_c;
  logic             cin0_c;

  assign b_eff_c = sub ? ~b : b;
  assign cin0_c  = c_in ^ sub;

  // Carry entering each stage: bit 0 is the operation carry-in.
  // Each higher bit is the carry registered by the stage below it.
  logic [STAGES-1:0] cin_c;
  // Fully aligned result presented to the output register.
  logic [WIDTH-1:0]  s_next_c;
  logic              c_out_c;
  logic              ovf_c;

  assign cin_c[0] = cin0_c;

  // Valid bit of each stage. The chain bit k is the valid bit that
  // accompanies the operands stage k is computing this cycle.
  logic [STAGES-1:0] vld_q;
  logic [STAGES:0]   vld_chain_c;

  assign vld_chain_c = {vld_q, in_valid};
  assign out_valid   = vld_chain_c[STAGES];

  // Valid shift register; reset discards every in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_chain_c[STAGES-1:0];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * CHUNK;

    logic [CHUNK-1:0] a_at_c;
    logic [CHUNK-1:0] b_at_c;
    logic [CHUNK:0]   add_c;

    if (k == 0) begin : g_no_skew
      assign a_at_c = a[LO +: CHUNK];
      assign b_at_c = b_eff_c[LO +: CHUNK];
    end else begin : g_skew
      // Input skew: delays chunk k by k cycles so it meets its carry.
      logic [CHUNK-1:0] a_skew_q [k];
      logic [CHUNK-1:0] b_skew_q [k];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < k; i++) begin
            a_skew_q[i] <= '0;
            b_skew_q[i] <= '0;
          end
        end else begin
          a_skew_q[0] <= a[LO +: CHUNK];
          b_skew_q[0] <= b_eff_c[LO +: CHUNK];
          for (int i = 1; i < k; i++) begin
            a_skew_q[i] <= a_skew_q[i-1];
            b_skew_q[i] <= b_skew_q[i-1];
          end
        end
      end

      assign a_at_c = a_skew_q[k-1];
      assign b_at_c = b_skew_q[k-1];
    end

    // CHUNK-bit slice of the carry chain.
    assign add_c = {1'b0, a_at_c} + {1'b0, b_at_c} + (CHUNK+1)'(cin_c[k]);

    if (k < STAGES - 1) begin : g_mid
      // Stage register for the carry. The sum chunk is kept in an output
      // deskew line so all chunks reach the output register together.
      logic             carry_q;
      logic [CHUNK-1:0] sum_dly_q [STAGES-1-k];

      always_ff @(posedge clk) begin
        if (rst) begin
          carry_q <= 1'b0;
          for (int i = 0; i < int'(STAGES - 1 - k); i++) begin
            sum_dly_q[i] <= '0;
          end
        end else begin
          carry_q      <= add_c[CHUNK];
          sum_dly_q[0] <= add_c[CHUNK-1:0];
          for (int i = 1; i < int'(STAGES - 1 - k); i++) begin
            sum_dly_q[i] <= sum_dly_q[i-1];
          end
        end
      end

      assign cin_c[k+1]            = carry_q;
      assign s_next_c[LO +: CHUNK] = sum_dly_q[STAGES-2-k];
    end else begin : g_last
      // The top chunk is registered directly into the outputs. The operand
      // MSBs are still available here, so the overflow check needs no state.
      assign s_next_c[LO +: CHUNK] = add_c[CHUNK-1:0];
      assign c_out_c               = add_c[CHUNK];
      assign ovf_c                 = (a_at_c[CHUNK-1] == b_at_c[CHUNK-1]) &&
                                     (add_c[CHUNK-1] != a_at_c[CHUNK-1]);
    end
  end

  // Output register: loads only for a valid final stage and otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      s     <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else if (vld_chain_c[STAGES-1]) begin
      s     <= s_next_c;
      c_out <= c_out_c;
      ovf   <= ovf_c;
    end
  end

endmodule
